// File: rtl/aes_pkg.sv
// Purpose : shared AES types, S-box and word helpers for key schedule and cipher rounds.
// Latency : combinational functions only; no state.
// Backpressure: n/a (package).
// Contents: aes_word_t, ks_state_t, SBOX, xtime/rot_word/sub_word, num_rounds/total_words.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic int num_rounds(input int nk);
    return nk + 6;
  endfunction

  function automatic int total_words(input int nk);
    return 4 * (nk + 7);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Purpose : 4-byte S-box substitution of one 32-bit word.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : i_word (word in), o_word (substituted word out).
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = sub_word(i_word);

endmodule

// File: rtl/aes_key_schedule.sv
// Purpose : self-sequenced AES key expansion (Nk = 4/6/8) with a 128-bit round-key read port.
// Latency : one expanded word per cycle, done after TOTAL_WORDS-Nk cycles; round-key reads take 1 cycle.
// Backpressure: none; start is ignored while expanding, reads are only served while done.
// Ports   : clk, rst (sync, active-high); start_i/key_i launch expansion; busy_o/done_o status;
//           rd_en_i/rd_round_i request a round key, returned on rk_o qualified by rd_valid_o.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [32*KEY_WORDS-1:0] key_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    rd_en_i,
  input  logic [3:0]              rd_round_i,
  output logic [127:0]            rk_o,
  output logic                    rd_valid_o
);

  localparam int NUM_ROUNDS  = num_rounds(KEY_WORDS);
  localparam int TOTAL_WORDS = total_words(KEY_WORDS);

  if (!(KEY_WORDS == 4 || KEY_WORDS == 6 || KEY_WORDS == 8)) begin : g_bad_key_words
    $error("aes_key_schedule: KEY_WORDS must be 4, 6 or 8");
  end

  ks_state_t   r_state;
  ks_state_t   w_state_nxt;
  logic [5:0]  r_idx;
  // r_phase tracks index mod Nk so no divider is needed.
  logic [2:0]  r_phase;
  logic [7:0]  r_rcon;
  aes_word_t   r_w [TOTAL_WORDS];
  logic [127:0] r_rk;
  logic        r_rd_valid;

  logic        w_load;
  logic        w_step;
  aes_word_t   w_t;
  aes_word_t   w_p;
  aes_word_t   w_sub_in;
  aes_word_t   w_sub_out;
  aes_word_t   w_new;
  logic [5:0]  w_rd_base;

  // Next-state logic: start is only honoured outside EXPAND.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_state_nxt = ST_EXPAND;
          w_load      = 1'b1;
        end
      end
      ST_EXPAND: begin
        w_step = 1'b1;
        if (r_idx == 6'(TOTAL_WORDS - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_t = r_w[r_idx - 6'd1];
  assign w_p = r_w[r_idx - 6'(KEY_WORDS)];

  // One shared S-box bank: rotated input on word-group boundaries, plain input for the Nk=8 mid-group word.
  assign w_sub_in = (r_phase == 3'd0) ? rot_word(w_t) : w_t;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_new = w_p ^ w_t;
    if (r_phase == 3'd0) begin
      w_new = w_p ^ w_sub_out ^ {r_rcon, 24'h0};
    end else if (KEY_WORDS == 8 && r_phase == 3'd4) begin
      w_new = w_p ^ w_sub_out;
    end
  end

  assign w_rd_base = {rd_round_i, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 6'd0;
      r_phase    <= 3'd0;
      r_rcon     <= 8'h01;
      r_rk       <= 128'h0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_idx   <= 6'(KEY_WORDS);
        r_phase <= 3'd0;
        r_rcon  <= 8'h01;
      end else if (w_step) begin
        r_idx   <= r_idx + 6'd1;
        r_phase <= (r_phase == 3'(KEY_WORDS - 1)) ? 3'd0 : r_phase + 3'd1;
        if (r_phase == 3'd0) begin
          r_rcon <= xtime(r_rcon);
        end
      end
      // A read on the same edge as a restart sees the old storage because writes are non-blocking.
      if (rd_en_i && r_state == ST_DONE) begin
        r_rd_valid <= 1'b1;
        if (rd_round_i > 4'(NUM_ROUNDS)) begin
          r_rk <= 128'h0;
        end else begin
          r_rk <= {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                   r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
        end
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Key storage is deliberately not cleared by reset; reads are gated by done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_load) begin
        for (int i = 0; i < KEY_WORDS; i++) begin
          r_w[i] <= key_i[32*(KEY_WORDS-i)-1 -: 32];
        end
      end else if (w_step) begin
        r_w[r_idx] <= w_new;
      end
    end
  end

  assign busy_o     = (r_state == ST_EXPAND);
  assign done_o     = (r_state == ST_DONE);
  assign rk_o       = r_rk;
  assign rd_valid_o = r_rd_valid;

endmodule
